// File: rtl/dpram_port_arbiter.sv
// Purpose: shares one 16x8 dual-port RAM between NREQ requesters, granting up to two requests per cycle round-robin (first winner on port A, second on port B).
// Latency: gnt is combinational; read data returns on rvalid/rdata 2 cycles after the grant cycle.
// Backpressure: a requester holds req until gnt; a same-address write hazard defers the port-B candidate by one cycle.
// Ports: clk/rst_n; req/req_we/req_addr/req_wdata from the clients (packed, slice i per requester);
//        gnt/rvalid/rdata back to the clients; ram_*_a/ram_*_b drive the RAM ports directly;
//        conflict_cnt is a saturating count of hazard-deferred cycles.
module dpram_port_arbiter #(
   parameter int NREQ = 4,
   parameter int AW   = 4,
   parameter int DW   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    req_we,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    rvalid,
   output logic [NREQ*DW-1:0] rdata,
   output logic [AW-1:0]      ram_addr_a,
   output logic [AW-1:0]      ram_addr_b,
   output logic [DW-1:0]      ram_din_a,
   output logic [DW-1:0]      ram_din_b,
   output logic               ram_we_a,
   output logic               ram_we_b,
   input  logic [DW-1:0]      ram_dout_a,
   input  logic [DW-1:0]      ram_dout_b,
   output logic [7:0]         conflict_cnt
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   typedef logic [IW-1:0] id_t;

   logic [AW-1:0] addr_arr  [NREQ];
   logic [DW-1:0] wdata_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign addr_arr[i]  = req_addr[i*AW +: AW];
      assign wdata_arr[i] = req_wdata[i*DW +: DW];
   end

   id_t         ptr;
   id_t         cand_a;
   id_t         cand_b;
   id_t         last_id;
   logic        cand_a_vld;
   logic        cand_b_vld;
   logic        hazard;
   logic        gnt_a;
   logic        gnt_b;
   logic [IW:0] scan_idx;

   // Rotating scan from ptr: first asserted requester is candidate A, second is B.
   always_comb begin
      cand_a_vld = 1'b0;
      cand_b_vld = 1'b0;
      cand_a     = '0;
      cand_b     = '0;
      scan_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = {1'b0, ptr} + (IW+1)'(k);
         if (scan_idx >= (IW+1)'(NREQ)) begin
            scan_idx = scan_idx - (IW+1)'(NREQ);
         end
         if (req[scan_idx[IW-1:0]]) begin
            if (!cand_a_vld) begin
               cand_a_vld = 1'b1;
               cand_a     = scan_idx[IW-1:0];
            end else if (!cand_b_vld) begin
               cand_b_vld = 1'b1;
               cand_b     = scan_idx[IW-1:0];
            end
         end
      end
   end

   // Same address with at least one write cannot share a cycle; two reads can.
   assign hazard  = cand_b_vld && (addr_arr[cand_a] == addr_arr[cand_b]) &&
                    (req_we[cand_a] || req_we[cand_b]);
   assign gnt_a   = rst_n && cand_a_vld;
   assign gnt_b   = rst_n && cand_b_vld && !hazard;
   assign last_id = gnt_b ? cand_b : cand_a;

   always_comb begin
      gnt        = '0;
      ram_we_a   = 1'b0;
      ram_addr_a = '0;
      ram_din_a  = '0;
      ram_we_b   = 1'b0;
      ram_addr_b = '0;
      ram_din_b  = '0;
      if (gnt_a) begin
         gnt[cand_a] = 1'b1;
         ram_we_a    = req_we[cand_a];
         ram_addr_a  = addr_arr[cand_a];
         ram_din_a   = wdata_arr[cand_a];
      end
      if (gnt_b) begin
         gnt[cand_b] = 1'b1;
         ram_we_b    = req_we[cand_b];
         ram_addr_b  = addr_arr[cand_b];
         ram_din_b   = wdata_arr[cand_b];
      end
   end

   // Pointer moves past the last requester served so every requester gets its turn.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (gnt_a) begin
         ptr <= (last_id == id_t'(NREQ-1)) ? '0 : last_id + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict_cnt <= '0;
      end else if (hazard && (conflict_cnt != 8'hFF)) begin
         conflict_cnt <= conflict_cnt + 8'd1;
      end
   end

   // Stage 1 tracks which requester owns each port's read while the RAM does its
   // registered read; stage 2 steers ram_dout back to that requester's slice.
   logic s1_rd_a;
   logic s1_rd_b;
   id_t  s1_id_a;
   id_t  s1_id_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_rd_a <= 1'b0;
         s1_rd_b <= 1'b0;
         s1_id_a <= '0;
         s1_id_b <= '0;
      end else begin
         s1_rd_a <= gnt_a && !req_we[cand_a];
         s1_rd_b <= gnt_b && !req_we[cand_b];
         s1_id_a <= cand_a;
         s1_id_b <= cand_b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid <= '0;
         rdata  <= '0;
      end else begin
         rvalid <= '0;
         for (int i = 0; i < NREQ; i++) begin
            if (s1_rd_a && (s1_id_a == id_t'(i))) begin
               rvalid[i]          <= 1'b1;
               rdata[i*DW +: DW]  <= ram_dout_a;
            end
            if (s1_rd_b && (s1_id_b == id_t'(i))) begin
               rvalid[i]          <= 1'b1;
               rdata[i*DW +: DW]  <= ram_dout_b;
            end
         end
      end
   end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a behavioural 16x8 read-first dual-port RAM.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_dpram_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [3:0]  req_we;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  gnt;
   logic [3:0]  rvalid;
   logic [31:0] rdata;
   logic [3:0]  ram_addr_a;
   logic [3:0]  ram_addr_b;
   logic [7:0]  ram_din_a;
   logic [7:0]  ram_din_b;
   logic        ram_we_a;
   logic        ram_we_b;
   logic [7:0]  ram_dout_a;
   logic [7:0]  ram_dout_b;
   logic [7:0]  conflict_cnt;

   int checks   = 0;
   int failures = 0;
   int cnt_g [4];
   logic [3:0] last_gnt;

   logic [7:0] mem [16] = '{default: 8'h00};

   dpram_port_arbiter #(.NREQ(4), .AW(4), .DW(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .gnt          (gnt),
      .rvalid       (rvalid),
      .rdata        (rdata),
      .ram_addr_a   (ram_addr_a),
      .ram_addr_b   (ram_addr_b),
      .ram_din_a    (ram_din_a),
      .ram_din_b    (ram_din_b),
      .ram_we_a     (ram_we_a),
      .ram_we_b     (ram_we_b),
      .ram_dout_a   (ram_dout_a),
      .ram_dout_b   (ram_dout_b),
      .conflict_cnt (conflict_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Read-first registered RAM
   always @(posedge clk) begin
      ram_dout_a <= mem[ram_addr_a];
      ram_dout_b <= mem[ram_addr_b];
      if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
      if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic we, input logic [3:0] a, input logic [7:0] d);
      req[i]             = 1'b1;
      req_we[i]          = we;
      req_addr[i*4 +: 4] = a;
      req_wdata[i*8 +: 8] = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      req       = 4'hF;
      req_we    = 4'h0;
      req_addr  = '0;
      req_wdata = '0;
      repeat (3) tick();

      // Reset with every request asserted
      @(negedge clk);
      chk("rst_gnt", gnt, 4'b0000);
      chk("rst_we_a", ram_we_a, 1'b0);
      chk("rst_we_b", ram_we_b, 1'b0);
      chk("rst_addr_a", ram_addr_a, 4'h0);
      chk("rst_din_b", ram_din_b, 8'h00);
      chk("rst_rvalid", rvalid, 4'b0000);
      chk("rst_conflict", conflict_cnt, 8'd0);
      rst_n = 1'b1;
      #1;
      chk("first_gnt", gnt, 4'b0011);
      tick();
      @(negedge clk);
      chk("second_gnt", gnt, 4'b1100);
      chk("rvalid_early", rvalid, 4'b0000);
      tick();
      req = 4'h0;
      @(negedge clk);
      chk("idle_gnt", gnt, 4'b0000);
      chk("rvalid_pair01", rvalid, 4'b0011);
      tick();
      @(negedge clk);
      chk("rvalid_pair23", rvalid, 4'b1100);
      tick();

      // Write 0xA5 to addr 3, then read it back (ptr = 0)
      set_req(2, 1'b1, 4'h3, 8'hA5);
      @(negedge clk);
      chk("wr_gnt", gnt, 4'b0100);
      chk("wr_we_a", ram_we_a, 1'b1);
      chk("wr_addr_a", ram_addr_a, 4'h3);
      chk("wr_din_a", ram_din_a, 8'hA5);
      chk("wr_we_b", ram_we_b, 1'b0);
      tick();
      req_we[2] = 1'b0;
      @(negedge clk);
      chk("rd_gnt", gnt, 4'b0100);
      chk("rd_we_a", ram_we_a, 1'b0);
      tick();
      req = 4'h0;
      @(negedge clk);
      chk("wr_no_rvalid", rvalid, 4'b0000);
      tick();
      @(negedge clk);
      chk("rd_rvalid", rvalid, 4'b0100);
      chk("rd_rdata2", rdata[23:16], 8'hA5);
      tick();
      @(negedge clk);
      chk("rd_rvalid_pulse", rvalid, 4'b0000);
      chk("rd_rdata2_hold", rdata[23:16], 8'hA5);

      // Dual read of addr 7 holding 0x3C (ptr = 3)
      set_req(3, 1'b1, 4'h7, 8'h3C);
      @(negedge clk);
      chk("prep_gnt", gnt, 4'b1000);
      tick();
      req = 4'h0;
      set_req(0, 1'b0, 4'h7, 8'h00);
      set_req(1, 1'b0, 4'h7, 8'h00);
      @(negedge clk);
      chk("dual_gnt", gnt, 4'b0011);
      chk("dual_addr_a", ram_addr_a, 4'h7);
      chk("dual_addr_b", ram_addr_b, 4'h7);
      chk("dual_we_b", ram_we_b, 1'b0);
      tick();
      req = 4'h0;
      tick();
      @(negedge clk);
      chk("dual_rvalid", rvalid, 4'b0011);
      chk("dual_rdata0", rdata[7:0], 8'h3C);
      chk("dual_rdata1", rdata[15:8], 8'h3C);
      chk("dual_conflict", conflict_cnt, 8'd0);

      // Bring ptr back to 0 (ptr = 2 here)
      set_req(3, 1'b0, 4'h0, 8'h00);
      @(negedge clk);
      chk("align_gnt", gnt, 4'b1000);
      tick();
      req = 4'h0;

      // Write/write hazard on addr 5
      set_req(0, 1'b1, 4'h5, 8'h11);
      set_req(1, 1'b1, 4'h5, 8'h22);
      @(negedge clk);
      chk("haz_gnt", gnt, 4'b0001);
      chk("haz_we_a", ram_we_a, 1'b1);
      chk("haz_din_a", ram_din_a, 8'h11);
      chk("haz_we_b", ram_we_b, 1'b0);
      chk("haz_addr_b", ram_addr_b, 4'h0);
      chk("haz_cnt_before", conflict_cnt, 8'd0);
      tick();
      req[0] = 1'b0;
      @(negedge clk);
      chk("haz_cnt", conflict_cnt, 8'd1);
      chk("haz_retry_gnt", gnt, 4'b0010);
      chk("haz_retry_din", ram_din_a, 8'h22);
      tick();
      req = 4'h0;
      set_req(2, 1'b0, 4'h5, 8'h00);
      @(negedge clk);
      chk("haz_rd_gnt", gnt, 4'b0100);
      tick();
      req = 4'h0;
      tick();
      @(negedge clk);
      chk("haz_rd_rvalid", rvalid, 4'b0100);
      chk("haz_rd_rdata2", rdata[23:16], 8'h22);
      chk("haz_cnt_after", conflict_cnt, 8'd1);

      // Persistent hazard saturates the counter (1 + 260 deferred cycles)
      last_gnt = 4'h0;
      set_req(0, 1'b1, 4'h9, 8'h55);
      set_req(1, 1'b1, 4'h9, 8'h66);
      for (int n = 0; n < 260; n++) begin
         @(negedge clk);
         last_gnt = gnt;
         tick();
      end
      req = req & ~last_gnt;
      @(negedge clk);
      chk("sat_cnt", conflict_cnt, 8'd255);
      tick();
      req = 4'h0;
      set_req(3, 1'b0, 4'h0, 8'h00);
      @(negedge clk);
      chk("sat_align_gnt", gnt, 4'b1000);
      chk("sat_cnt_hold", conflict_cnt, 8'd255);
      tick();
      req = 4'h0;

      // Fairness: four continuous readers starting from ptr = 0
      for (int i = 0; i < 4; i++) begin
         cnt_g[i] = 0;
         set_req(i, 1'b0, 4'(i), 8'h00);
      end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk($sformatf("fair_gnt_c%0d", c), gnt, (c % 2 == 0) ? 32'h3 : 32'hC);
         for (int i = 0; i < 4; i++) begin
            if (gnt[i]) cnt_g[i]++;
         end
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("fair_count_req%0d", i), cnt_g[i], 32'd10);
      end

      // Reset while a read is in flight (ptr = 0)
      req = 4'h0;
      set_req(0, 1'b0, 4'h7, 8'h00);
      @(negedge clk);
      chk("mid_gnt", gnt, 4'b0001);
      tick();
      req = 4'h0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_rvalid", rvalid, 4'b0000);
      chk("mid_rst_rdata", rdata, 32'h0);
      chk("mid_rst_cnt", conflict_cnt, 8'd0);
      chk("mid_rst_we_a", ram_we_a, 1'b0);
      rst_n = 1'b1;
      tick();
      @(negedge clk);
      chk("mid_no_rvalid_t2", rvalid, 4'b0000);
      tick();
      @(negedge clk);
      chk("mid_no_rvalid_t3", rvalid, 4'b0000);
      chk("mid_rdata_clear", rdata, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
